// File: rtl/fetch_mem_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_mem_sequencer_pkg
//   Shared definitions for the fetch/memory sequencer of the 16-bit core:
//   - seq_state_t : one-hot sequencer state encoding (ST_IDLE .. ST_HALTED)
//   - DATA_W      : core data/address width
//   - TIMEOUT_CYCLES_DEFAULT / timeout_cnt_width() : sizing for the optional
//     bus watchdog (built only when SEQ_BUS_TIMEOUT_EN is defined)
// ---------------------------------------------------------------------------
package fetch_mem_sequencer_pkg;

  localparam int unsigned DATA_W                 = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  // One-hot so that any corrupted pattern is easy to catch and steer to IDLE.
  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_FETCH  = 6'b000010,
    ST_EXEC   = 6'b000100,
    ST_MEM    = 6'b001000,
    ST_COMMIT = 6'b010000,
    ST_HALTED = 6'b100000
  } seq_state_t;

  // Width of a counter that must be able to hold the value max_cycles.
  function automatic int unsigned timeout_cnt_width(input int unsigned max_cycles);
    int unsigned w;
    if (max_cycles < 1) w = 1;
    else                w = $clog2(max_cycles + 1);
    return w;
  endfunction

endpackage

// File: rtl/fetch_mem_sequencer_bus_watchdog.sv
// ---------------------------------------------------------------------------
// bus_watchdog
//   Wait-cycle counter for the shared memory port. Counts consecutive cycles
//   in which a request is outstanding without mem_ready, and flags expiry on
//   the cycle whose clock edge brings the count to TIMEOUT_CYCLES.
//   Compiled only when SEQ_BUS_TIMEOUT_EN is defined.
// Ports
//   clk        in   core clock
//   reset      in   asynchronous active-low reset
//   busy       in   sequencer is in FETCH or MEM (mem_req is high)
//   mem_ready  in   memory handshake
//   expired    out  combinational: this cycle is the last allowed wait cycle
//   bus_error  out  sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
`ifdef SEQ_BUS_TIMEOUT_EN
module bus_watchdog
  import fetch_mem_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic mem_ready,
  output logic expired,
  output logic bus_error
);

  localparam int unsigned     CNT_W     = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg, count_next;
  logic             bus_error_reg, bus_error_next;
  logic             waiting;

  assign waiting = busy && !mem_ready;
  // The count reaches TIMEOUT_CYCLES on this edge; the sequencer abandons the
  // request instead of waiting one more cycle.
  assign expired = waiting && (count_reg == LAST_WAIT);

  always_comb begin
    count_next     = '0;  // zero whenever not waiting -> clear on entry
    bus_error_next = bus_error_reg | expired;
    if (waiting) count_next = count_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg     <= '0;
      bus_error_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      bus_error_reg <= bus_error_next;
    end
  end

  assign bus_error = bus_error_reg;

endmodule
`endif

// File: rtl/fetch_mem_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_mem_sequencer
//   Multi-cycle control sequencer for the 16-bit core. Shares one memory port
//   between instruction fetch and LOAD/STOR data access, latches the fetched
//   instruction, and produces the one-cycle clk_en pulse that advances the
//   datapath exactly once per instruction.
//   Sequence: IDLE -> FETCH -> EXEC -> [MEM] -> COMMIT -> FETCH/IDLE/HALTED.
//
// Optional feature macro: SEQ_BUS_TIMEOUT_EN
//   defined   : a bus_watchdog aborts FETCH/MEM after TIMEOUT_CYCLES wait
//               cycles, sets sticky bus_error and parks in HALTED
//   undefined : FETCH/MEM wait indefinitely, bus_error tied to 0
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   run                        1 = keep executing, 0 = park in IDLE after the
//                              current instruction (sampled in IDLE/COMMIT)
//   pc                         fetch address
//   alu_result, regD_data      LOAD/STOR address and STOR data
//   load, store, halt_cmd      decode flags of the latched instruction
//   mem_req/we/addr/wdata      memory request side
//   mem_rdata, mem_ready       memory response side
//   instruction, load_data     latched fetch word and LOAD data
//   wr_load, clk_en            write-back select and datapath advance pulse
//   halted, bus_error          status
// ---------------------------------------------------------------------------
module fetch_mem_sequencer
  import fetch_mem_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] regD_data,
  input  logic              load,
  input  logic              store,
  input  logic              halt_cmd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] load_data,
  output logic              wr_load,
  output logic              clk_en,
  output logic              halted,
  output logic              bus_error
);

  seq_state_t        state_reg, state_next;
  logic [DATA_W-1:0] instruction_reg, instruction_next;
  logic [DATA_W-1:0] load_data_reg, load_data_next;
  logic              write_sel;
  logic              timeout_hit;

  // State and latches. Request outputs are decoded from state_reg, so an
  // asynchronous reset drops mem_req immediately, abandoning any transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      instruction_reg <= '0;
      load_data_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      instruction_reg <= instruction_next;
      load_data_reg   <= load_data_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    instruction_next = instruction_reg;
    load_data_next   = load_data_reg;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    write_sel        = 1'b0;
    clk_en           = 1'b0;
    wr_load          = 1'b0;
    halted           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end

      ST_FETCH: begin
        // pc cannot move here (clk_en is low), so the address stays stable
        // across wait states without a separate address register.
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) begin
          instruction_next = mem_rdata;
          state_next       = ST_EXEC;
        end else if (timeout_hit) begin
          state_next = ST_HALTED;
        end
      end

      ST_EXEC: begin
        // One settle cycle so decode flags and alu_result reflect the newly
        // latched instruction before the data access is issued.
        if (load || store) state_next = ST_MEM;
        else               state_next = ST_COMMIT;
      end

      ST_MEM: begin
        mem_req   = 1'b1;
        mem_we    = store;
        write_sel = store;
        mem_addr  = alu_result;
        if (mem_ready) begin
          if (load) load_data_next = mem_rdata;
          state_next = ST_COMMIT;
        end else if (timeout_hit) begin
          state_next = ST_HALTED;
        end
      end

      ST_COMMIT: begin
        clk_en  = 1'b1;
        wr_load = load;
        if (halt_cmd)  state_next = ST_HALTED;
        else if (!run) state_next = ST_IDLE;
        else           state_next = ST_FETCH;
      end

      ST_HALTED: begin
        halted = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Write data is forced to zero on reads and outside MEM.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_wdata
      assign mem_wdata[gi] = regD_data[gi] & write_sel;
    end
  endgenerate

  assign instruction = instruction_reg;
  assign load_data   = load_data_reg;

`ifdef SEQ_BUS_TIMEOUT_EN
  logic in_bus;
  assign in_bus = (state_reg == ST_FETCH) || (state_reg == ST_MEM);

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_watchdog (
    .clk       (clk),
    .reset     (reset),
    .busy      (in_bus),
    .mem_ready (mem_ready),
    .expired   (timeout_hit),
    .bus_error (bus_error)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
  assign bus_error          = 1'b0;
`endif

endmodule
